// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame-length helpers
// used by the transmit core (and a future receive core).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic int frame_bits(int data_bits, int parity_en, int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

  function automatic int frame_clks(int clks_per_bit, int data_bits, int parity_en,
                                    int stop_bits);
    return frame_bits(data_bits, parity_en, stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: reloads to CLKS_PER_BIT-1 on clear, counts down while
// enabled and pulses bit_tick during the last clock of each bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - CNT_W'(1);
    end
  end

  assign bit_tick = en && (cnt == '0);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready byte intake, start + LSB-first data +
// optional parity + 1/2 stop bits on a registered, idle-high serial line.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_core: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_core: DATA_BITS must be in 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 par_bit;
  logic                 bit_tick;
  logic                 accept;

  assign accept = tx_valid && tx_ready;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (busy),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            shreg    <= tx_data;
            par_bit  <= (^tx_data) ^ PAR_INV;
            bit_idx  <= '0;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_DATA) begin
              // bit_idx is reused to count stop bits
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (bit_idx == LAST_STOP) begin
              state    <= IDLE;
              bit_idx  <= '0;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: four instances (plain, even parity, odd parity,
// two stop bits) checked cycle by cycle against a frame-level model.
module tb_uart_tx_core;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic [3:0] tx_valid;
  logic [3:0] tx_ready;
  logic [3:0] tx;
  logic [3:0] busy;

  int vectors = 0;
  int errors  = 0;

  // per-instance configuration as seen by the model
  int cfg_pe [4] = '{0, 1, 1, 0};
  int cfg_po [4] = '{0, 0, 1, 0};
  int cfg_sb [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_core #(.CLKS_PER_BIT(CPB)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx(tx[0]), .busy(busy[0])
  );
  uart_tx_core #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx(tx[1]), .busy(busy[1])
  );
  uart_tx_core #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx(tx[2]), .busy(busy[2])
  );
  uart_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx(tx[3]), .busy(busy[3])
  );

  function automatic int flen(int i);
    return (1 + 8 + cfg_pe[i] + cfg_sb[i]) * CPB;
  endfunction

  // Line level expected k clocks after the accepting edge.
  function automatic logic exp_tx(int i, logic [7:0] d, int k);
    int b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (cfg_pe[i] != 0 && b == 9) return (^d) ^ (cfg_po[i] != 0);
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one-cycle valid pulse; returns in the first start-bit clock.
  task automatic handshake(int i, logic [7:0] d);
    tx_data     = d;
    tx_valid[i] = 1'b1;
    step();
    tx_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (tx[i] !== 1'b1 || tx_ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d tx=%b rdy=%b busy=%b expected 1 1 0",
                 i, tx[i], tx_ready[i], busy[i]);
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_a5();
    logic [7:0] d = 8'hA5;
    handshake(0, d);
    for (int k = 0; k < flen(0); k++) begin
      vectors++;
      if (tx[0] !== exp_tx(0, d, k) || tx_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL a5 k=%0d tx=%b rdy=%b busy=%b expected tx=%b rdy=0 busy=1",
                 k, tx[0], tx_ready[0], busy[0], exp_tx(0, d, k));
      end
      step();
    end
    vectors++;
    if (tx[0] !== 1'b1 || tx_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL a5_end tx=%b rdy=%b busy=%b expected 1 1 0", tx[0], tx_ready[0], busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    tx_data     = 8'h00;
    tx_valid[0] = 1'b1;
    step();
    tx_data = 8'hFF;
    for (int k = 0; k < flen(0); k++) begin
      vectors++;
      if (tx[0] !== exp_tx(0, 8'h00, k) || tx_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_f1 k=%0d tx=%b rdy=%b expected tx=%b rdy=0",
                 k, tx[0], tx_ready[0], exp_tx(0, 8'h00, k));
      end
      step();
    end
    vectors++;
    if (tx[0] !== 1'b1 || tx_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap tx=%b rdy=%b busy=%b expected 1 1 0", tx[0], tx_ready[0], busy[0]);
    end
    step();
    tx_valid[0] = 1'b0;
    for (int k = 0; k < flen(0); k++) begin
      vectors++;
      if (tx[0] !== exp_tx(0, 8'hFF, k) || tx_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_f2 k=%0d tx=%b rdy=%b expected tx=%b rdy=0",
                 k, tx[0], tx_ready[0], exp_tx(0, 8'hFF, k));
      end
      step();
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (tx[0] !== 1'b1 || tx_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle k=%0d tx=%b rdy=%b busy=%b expected 1 1 0",
                 k, tx[0], tx_ready[0], busy[0]);
      end
      step();
    end
  endtask

  task automatic test_parity();
    for (int i = 1; i <= 2; i++) begin
      logic [7:0] d = 8'h07;
      vectors++;
      if (flen(i) != 44) begin
        errors++;
        $display("FAIL parity_len dut%0d model=%0d expected 44", i, flen(i));
      end
      handshake(i, d);
      for (int k = 0; k < flen(i); k++) begin
        vectors++;
        if (tx[i] !== exp_tx(i, d, k) || busy[i] !== 1'b1) begin
          errors++;
          $display("FAIL parity dut%0d k=%0d tx=%b busy=%b expected tx=%b busy=1",
                   i, k, tx[i], busy[i], exp_tx(i, d, k));
        end
        step();
      end
      vectors++;
      if (tx_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL parity_end dut%0d rdy=%b expected 1", i, tx_ready[i]);
      end
    end
  endtask

  task automatic test_stop2();
    logic [7:0] d = 8'h80;
    handshake(3, d);
    for (int k = 0; k < flen(3); k++) begin
      vectors++;
      if (tx[3] !== exp_tx(3, d, k) || tx_ready[3] !== 1'b0) begin
        errors++;
        $display("FAIL stop2 k=%0d tx=%b rdy=%b expected tx=%b rdy=0",
                 k, tx[3], tx_ready[3], exp_tx(3, d, k));
      end
      step();
    end
    vectors++;
    if (tx_ready[3] !== 1'b1 || tx[3] !== 1'b1) begin
      errors++;
      $display("FAIL stop2_end rdy=%b tx=%b expected 1 1", tx_ready[3], tx[3]);
    end
  endtask

  task automatic test_mid_change();
    logic [7:0] d = 8'($urandom);
    handshake(0, d);
    for (int k = 0; k < flen(0); k++) begin
      tx_data = 8'($urandom);
      vectors++;
      if (tx[0] !== exp_tx(0, d, k)) begin
        errors++;
        $display("FAIL mid_change k=%0d tx=%b expected %b (latched %02h)",
                 k, tx[0], exp_tx(0, d, k), d);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) begin
        logic [7:0] d = 8'($urandom);
        handshake(i, d);
        for (int k = 0; k < flen(i); k++) begin
          vectors++;
          if (tx[i] !== exp_tx(i, d, k) || tx_ready[i] !== 1'b0) begin
            errors++;
            $display("FAIL random dut%0d data=%02h k=%0d tx=%b rdy=%b expected tx=%b rdy=0",
                     i, d, k, tx[i], tx_ready[i], exp_tx(i, d, k));
          end
          step();
        end
        vectors++;
        if (tx_ready[i] !== 1'b1 || tx[i] !== 1'b1) begin
          errors++;
          $display("FAIL random_end dut%0d rdy=%b tx=%b expected 1 1", i, tx_ready[i], tx[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'hD9;
    logic [7:0] d2 = 8'h3C;
    handshake(0, d);
    repeat (4 * CPB + 1) step();
    vectors++;
    if (tx[0] !== d[3]) begin
      errors++;
      $display("FAIL rst_mid_bit3 tx=%b expected %b", tx[0], d[3]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (tx[0] !== 1'b1 || tx_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid tx=%b rdy=%b busy=%b expected 1 1 0", tx[0], tx_ready[0], busy[0]);
    end
    handshake(0, d2);
    for (int k = 0; k < flen(0); k++) begin
      vectors++;
      if (tx[0] !== exp_tx(0, d2, k)) begin
        errors++;
        $display("FAIL rst_mid_3c k=%0d tx=%b expected %b", k, tx[0], exp_tx(0, d2, k));
      end
      step();
    end
    vectors++;
    if (tx_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_3c_end rdy=%b expected 1", tx_ready[0]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = '0;
    tx_data  = '0;
    step();
    test_reset();
    test_basic_a5();
    step();
    test_back_to_back();
    test_parity();
    step();
    test_stop2();
    step();
    test_mid_change();
    step();
    test_random();
    step();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Byte-serial UART transmitter: accepts parallel bytes on a valid/ready handshake and drives an asynchronous serial line (start, data LSB-first, optional parity, stop).
- Output-direction counterpart to the chip's pin-level input logic: turns on-chip data into a serial stream on a dedicated output pin.
- Instantiated inside the tt_um top-level wrapper, which maps ui_in to tx_data, uio_in[0] to tx_valid, uo_out[0] to tx, uo_out[1] to tx_ready and uo_out[2] to busy.
- The wrapper also generates rst as the synchronised inverse of rst_n.

Parameters:
- CLKS_PER_BIT, 87: clk cycles per serial bit (10 MHz / 115200); legal range >= 2.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- tx_data, input, DATA_BITS: byte to send; sampled only on handshake.
- tx_valid, input, 1: producer has data.
- tx_ready, output, 1: core can accept a byte this cycle.
- tx, output, 1: serial line, idle high.
- busy, output, 1: frame in progress.

Behaviour:
- Reset (rst=1 at a clk edge): next cycle tx=1, tx_ready=1, busy=0, state=IDLE, bit counter and shift register cleared. Reset mid-frame aborts the frame; tx is high the cycle after the reset edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- tx_ready=1 only in IDLE; busy = !tx_ready. Both are registered.
- Handshake: accept when tx_valid && tx_ready at an edge (cycle N). tx_data is latched into the shift register. If PARITY_EN=1, parity is computed from the latched data: even gives XOR of the bits, odd gives its inverse.
- tx_data and tx_valid are ignored whenever tx_ready=0. The producer may hold tx_valid high; no byte is lost or duplicated.
- tx is a registered output driven from state and shift register, never combinationally from inputs.
- Bit timing: start bit (tx=0) occupies cycles N+1 .. N+CLKS_PER_BIT. Every later bit also lasts exactly CLKS_PER_BIT cycles.
- Bit order: DATA_BITS data bits LSB-first, then the parity bit if enabled, then STOP_BITS stop bits (tx=1).
- Transitions:
  - IDLE->START on handshake.
  - START->DATA after CLKS_PER_BIT cycles.
  - DATA->PARITY (or ->STOP) after the last data bit.
  - PARITY->STOP.
  - STOP->IDLE after the final stop bit.
- Frame length F = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles. Frame ends at cycle N+F; tx_ready=1 from cycle N+F+1.
- Back-to-back throughput: with tx_valid held high, a new start bit begins every F+1 cycles, giving exactly one extra idle-high clk cycle between frames.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; the bit index advances on wrap. Counter width is clog2(CLKS_PER_BIT).
- Bit index width is clog2(DATA_BITS+1). No arithmetic overflow is possible in legal configurations.
- Illegal parameters (CLKS_PER_BIT<2, DATA_BITS outside 5..8, STOP_BITS not 1 or 2) trigger an elaboration-time $error.

Decomposition:
- Package uart_pkg holds:
  - state enum uart_state_e (IDLE, START, DATA, PARITY, STOP);
  - localparam helpers for the frame-length calculation, shared with a future uart_rx_core.
- One natural sub-module, uart_baud_cnt: CLKS_PER_BIT down-counter with synchronous clear and a one-cycle bit_tick output. The FSM, shift register and parity stay in uart_tx_core.

Test Plan:
- CLKS_PER_BIT=4, default config: 1-cycle pulse tx_valid with tx_data=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. tx_ready=0 for cycles N+1..N+40, then 1 at N+41.
- tx_valid held high with bytes 0x00 then 0xFF -> two frames. Second start bit falls at N+42; exactly one idle clk between frames; no duplicate byte.
- PARITY_EN=1, even parity, byte 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame is 44 cycles at CLKS_PER_BIT=4.
- STOP_BITS=2, byte 0x80 -> data bit 7 = 1, followed by 8 cycles of tx=1 before tx_ready returns.
- Change tx_data mid-frame -> transmitted bits match the value latched at the handshake.
- rst asserted for one cycle during DATA bit 3 -> next cycle tx=1, tx_ready=1, busy=0. A fresh 0x3C frame then transmits correctly.
